// File: rtl/timestamp_pkg.sv
// Shared timestamp width and port-counter state encoding for the DTP datapath
// (port counters and the global max stage).
package timestamp_pkg;

    localparam int unsigned TS_W = 53;

    typedef logic [TS_W-1:0] ts_t;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_BEACON = 2'd1,
        ST_LOCKED = 2'd2,
        ST_UNUSED = 2'd3
    } dtp_state_t;

endpackage

// File: rtl/dtp_port_counter_if.sv
// Receive-side strobe and counter status bundle of one DTP port counter.
interface dtp_port_counter_if;
    import timestamp_pkg::*;

    logic          enable;
    logic          rx_valid;
    ts_t           rx_timestamp;
    ts_t           timestamp;
    logic          synced;
    dtp_state_t    state;
    logic          jump;
    logic [15:0]   error_count;

    modport master (
        output enable, rx_valid, rx_timestamp,
        input  timestamp, synced, state, jump, error_count
    );

    modport slave (
        input  enable, rx_valid, rx_timestamp,
        output timestamp, synced, state, jump, error_count
    );

endinterface

// File: rtl/ts_max2.sv
// Combinational unsigned maximum of two timestamps; also used by the global max stage.
module ts_max2
    import timestamp_pkg::*;
(
    input  ts_t a,
    input  ts_t b,
    output ts_t y
);

    always_comb begin
        y = (a > b) ? a : b;
    end

endmodule

// File: rtl/dtp_port_counter.sv
// Local DTP counter for one port: follows peer timestamps, locks after a run of
// in-tolerance receptions and drops back to BEACON on large jumps or silence.
module dtp_port_counter
    import timestamp_pkg::*;
#(
    parameter int unsigned RX_DELAY    = 1,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned JUMP_THRESH = 4,
    parameter int unsigned TIMEOUT     = 1024
) (
    input logic               clock,
    input logic               reset,
    dtp_port_counter_if.slave port
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);
    localparam logic [TMR_W-1:0]  TMR_EXP   = TMR_W'(TIMEOUT);

    dtp_state_t        state_q, state_n;
    ts_t               ts_q, ts_n;
    logic [GOOD_W-1:0] good_q, good_n;
    logic [TMR_W-1:0]  tmr_q, tmr_n;
    logic [15:0]       err_q, err_n;
    logic              jump_q, jump_n;
    logic              synced_q;

    ts_t cand_local, cand_rx, cand_max, diff;

    always_comb begin
        cand_local = ts_q + ts_t'(1);
        cand_rx    = port.rx_timestamp + ts_t'(RX_DELAY);
        diff       = (cand_rx > cand_local) ? (cand_rx - cand_local) : '0;
    end

    ts_max2 u_max (
        .a (cand_local),
        .b (cand_rx),
        .y (cand_max)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_INIT;
            ts_q     <= '0;
            good_q   <= '0;
            tmr_q    <= '0;
            err_q    <= '0;
            jump_q   <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            ts_q     <= ts_n;
            good_q   <= good_n;
            tmr_q    <= tmr_n;
            err_q    <= err_n;
            jump_q   <= jump_n;
            synced_q <= (state_n == ST_LOCKED);
        end
    end

    always_comb begin
        state_n = state_q;
        ts_n    = ts_q;
        good_n  = good_q;
        tmr_n   = tmr_q;
        err_n   = err_q;
        jump_n  = 1'b0;
        if (port.enable) begin
            case (state_q)
                ST_INIT: begin
                    if (port.rx_valid) begin
                        ts_n    = cand_rx;
                        state_n = ST_BEACON;
                        good_n  = '0;
                        tmr_n   = '0;
                    end
                end
                ST_BEACON, ST_LOCKED: begin
                    ts_n = port.rx_valid ? cand_max : cand_local;
                    if (port.rx_valid) begin
                        // A reception always clears the idle timer, even on the expiry cycle.
                        tmr_n  = '0;
                        jump_n = (diff != '0);
                        if (diff > ts_t'(JUMP_THRESH)) begin
                            good_n = '0;
                            if (state_q == ST_LOCKED) begin
                                state_n = ST_BEACON;
                                if (err_q != '1) err_n = err_q + 16'd1;
                            end
                        end else begin
                            if (good_q != GOOD_LOCK) good_n = good_q + 1'b1;
                            if (state_q == ST_BEACON && good_n == GOOD_LOCK) state_n = ST_LOCKED;
                        end
                    end else begin
                        tmr_n = tmr_q + 1'b1;
                        if (tmr_n == TMR_EXP) begin
                            state_n = ST_BEACON;
                            good_n  = '0;
                            tmr_n   = '0;
                        end
                    end
                end
                default: begin
                    state_n = ST_INIT;
                    ts_n    = '0;
                    good_n  = '0;
                    tmr_n   = '0;
                end
            endcase
        end
    end

    assign port.timestamp   = ts_q;
    assign port.state       = state_q;
    assign port.synced      = synced_q;
    assign port.jump        = jump_q;
    assign port.error_count = err_q;

endmodule

// File: doc/dtp_port_counter.md
DTP_PORT_COUNTER -- requirements
Module: dtp_port_counter

Interface
REQ-001 Parameter RX_DELAY, default 1: fixed link latency added to received timestamps.
REQ-002 Parameter LOCK_COUNT, default 8: consecutive good receptions needed to lock.
REQ-003 Parameter JUMP_THRESH, default 4: largest forward correction still counted as good.
REQ-004 Parameter TIMEOUT, default 1024: cycles with no reception before lock is lost.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous reset, active-high.
REQ-007 enable  in  1  when low, all state holds and rx_valid is ignored.
REQ-008 rx_valid  in  1  one-cycle strobe: rx_timestamp holds a peer timestamp.
REQ-009 rx_timestamp  in  53  peer counter value, unsigned.
REQ-010 timestamp  out  53  registered local counter; feeds one timestamp_pX input of the global max stage.
REQ-011 synced  out  1  high while in LOCKED.
REQ-012 state  out  2  current state encoding.
REQ-013 jump  out  1  one-cycle pulse when a reception moved the counter forward.
REQ-014 error_count  out  16  number of lock losses caused by jumps.

Function
REQ-015 States SHALL be INIT=0, BEACON=1, LOCKED=2; encoding 3 is unused and SHALL return to INIT.
REQ-016 Definitions: cand_local = timestamp+1 mod 2^53; cand_rx = rx_timestamp+RX_DELAY mod 2^53; all compares are unsigned 53-bit, with no wrap-aware compare.
REQ-017 INIT: timestamp SHALL hold 0; on rx_valid, timestamp <= cand_rx, go to BEACON, clear good_cnt and idle timer, no jump pulse.
REQ-018 BEACON/LOCKED: timestamp <= max(cand_local, cand_rx) if rx_valid, else cand_local.
REQ-019 diff = cand_rx - cand_local when cand_rx > cand_local, else 0; jump SHALL pulse when diff > 0.
REQ-020 diff > JUMP_THRESH:
  - LOCKED: go to BEACON, clear good_cnt, error_count++ (saturating at 0xFFFF).
  - BEACON: clear good_cnt only.
REQ-021 rx_valid with diff <= JUMP_THRESH: good_cnt++. BEACON goes to LOCKED in the cycle good_cnt reaches LOCK_COUNT.
REQ-022 Idle timer: clears on rx_valid, otherwise increments. On reaching TIMEOUT in BEACON or LOCKED: go to BEACON, clear good_cnt and timer. The counter keeps running.
REQ-023 rx_valid in the same cycle as timer expiry: the reception wins and the timer clears.
REQ-024 Latency: a reception in cycle N SHALL be visible on timestamp, jump and state in cycle N+1.
REQ-025 Wrap: timestamp 2^53-1 SHALL advance to 0. cand_rx wraps modulo 2^53 before the max.
REQ-026 enable low SHALL freeze timestamp, state, timer, good_cnt and error_count, and SHALL force jump to 0.

Reset
REQ-027 reset SHALL set timestamp=0, state=INIT, synced=0, jump=0, error_count=0, good_cnt=0, timer=0.
REQ-028 reset SHALL take priority over enable and rx_valid. A reset in mid-lock SHALL return to INIT in the next cycle.

Structure
REQ-029 The shared package timestamp_pkg SHALL hold TS_W=53 and the dtp_state_t enum; the global max stage SHALL use TS_W from it.
REQ-030 One sub-module, ts_max2: a combinational 2-input unsigned TS_W max, reusable by the global max stage.
REQ-031 All outputs SHALL be registered; there is no combinational path from an input to an output.

Verification
REQ-032 Reset, enable=1, no rx for 5 cycles -> timestamp=0, state=INIT throughout.
REQ-033 rx_valid with rx_timestamp=100 in INIT -> next cycle timestamp=101, state=BEACON, jump=0; it then counts 102, 103, ...
REQ-034 Eight in-tolerance receptions (each rx = timestamp-1) -> synced=1 in the cycle after the 8th; jump never pulses.
REQ-035 LOCKED at timestamp 1000, rx_timestamp=2000 -> next cycle timestamp=2001, jump=1, state=BEACON, error_count=1.
REQ-036 LOCKED with no rx for 1024 cycles -> state=BEACON, synced=0, counter still incrementing; an rx exactly on expiry keeps LOCKED.
REQ-037 timestamp=2^53-2 with no rx -> values 2^53-1 then 0 on consecutive cycles; rx_timestamp=2^53-1 in INIT -> timestamp=0.
